// File: rtl/sawtooth_cfg_ctrl.sv
// Round-robin arbiter and config sequencer for the sawtooth datapath (align -> N1 -> N2 -> CALC).
// Range errors ack 2 cycles after grant; requests are level-held until their one-cycle ack.
module sawtooth_cfg_ctrl #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 15
) (
   input  logic             clc_i,
   input  logic             rst_i,
   input  logic [1:0]       req_i,
   input  logic [WIDTH-1:0] n1_a_i,
   input  logic [WIDTH-1:0] n2_a_i,
   input  logic [WIDTH-1:0] n1_b_i,
   input  logic [WIDTH-1:0] n2_b_i,
   input  logic [1:0]       dp_state_i,
   output logic [1:0]       ack_o,
   output logic [1:0]       err_code_o,
   output logic             busy_o,
   output logic             owner_o,
   output logic             v_o,
   output logic [WIDTH-1:0] din_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] DP_N1   = 2'd1;
   localparam logic [1:0] DP_N2   = 2'd2;
   localparam logic [1:0] DP_CALC = 2'd3;

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_RANGE   = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CHECK,
      S_ALIGN_P,
      S_ALIGN_W,
      S_N1_P,
      S_N1_W,
      S_N2_P,
      S_N2_W,
      S_FINISH
   } state_t;

   state_t           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic             owner_q, owner_d;
   logic [WIDTH-1:0] n1_q, n1_d;
   logic [WIDTH-1:0] n2_q, n2_d;
   logic [WIDTH-1:0] din_q, din_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [1:0]       align_q, align_d;
   logic [1:0]       ref_q, ref_d;
   logic [1:0]       err_q, err_d;
   logic [CW-1:0]    cnt_inc;
   logic             timeout_hit;
   logic             grant_b;

   assign cnt_inc     = cnt_q + 1'b1;
   assign timeout_hit = (cnt_inc == CW'(TIMEOUT));

   always_ff @(posedge clc_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         ptr_q   <= 1'b0;
         owner_q <= 1'b0;
         n1_q    <= '0;
         n2_q    <= '0;
         din_q   <= '0;
         cnt_q   <= '0;
         align_q <= '0;
         ref_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         n1_q    <= n1_d;
         n2_q    <= n2_d;
         din_q   <= din_d;
         cnt_q   <= cnt_d;
         align_q <= align_d;
         ref_q   <= ref_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      n1_d    = n1_q;
      n2_d    = n2_q;
      din_d   = din_q;
      cnt_d   = '0;
      align_d = align_q;
      ref_d   = ref_q;
      err_d   = err_q;
      grant_b = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (|req_i) begin
               // ptr_q = 1 means B is favoured when both are requesting
               grant_b = req_i[1] & (~req_i[0] | ptr_q);
               owner_d = grant_b;
               ptr_d   = ~grant_b;
               n1_d    = grant_b ? n1_b_i : n1_a_i;
               n2_d    = grant_b ? n2_b_i : n2_a_i;
               align_d = '0;
               err_d   = ERR_OK;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (n2_q <= n1_q) begin
               err_d   = ERR_RANGE;
               state_d = S_FINISH;
            end else if (dp_state_i == DP_N1) begin
               din_d   = n1_q;
               state_d = S_N1_P;
            end else begin
               din_d   = n2_q;
               align_d = align_q + 2'd1;
               state_d = S_ALIGN_P;
            end
         end
         S_ALIGN_P: begin
            ref_d   = dp_state_i;
            state_d = S_ALIGN_W;
         end
         S_ALIGN_W: begin
            cnt_d = cnt_inc;
            if (dp_state_i == DP_N1) begin
               din_d   = n1_q;
               state_d = S_N1_P;
            end else if (dp_state_i != ref_q) begin
               // datapath moved but not to N1: another pulse, at most three in total
               if (align_q == 2'd3) begin
                  err_d   = ERR_TIMEOUT;
                  state_d = S_FINISH;
               end else begin
                  din_d   = n2_q;
                  align_d = align_q + 2'd1;
                  state_d = S_ALIGN_P;
               end
            end else if (timeout_hit) begin
               err_d   = ERR_TIMEOUT;
               state_d = S_FINISH;
            end
         end
         S_N1_P: begin
            state_d = S_N1_W;
         end
         S_N1_W: begin
            cnt_d = cnt_inc;
            if (dp_state_i == DP_N2) begin
               din_d   = n2_q;
               state_d = S_N2_P;
            end else if (timeout_hit) begin
               err_d   = ERR_TIMEOUT;
               state_d = S_FINISH;
            end
         end
         S_N2_P: begin
            state_d = S_N2_W;
         end
         S_N2_W: begin
            cnt_d = cnt_inc;
            if (dp_state_i == DP_CALC) begin
               err_d   = ERR_OK;
               state_d = S_FINISH;
            end else if (timeout_hit) begin
               err_d   = ERR_TIMEOUT;
               state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // outputs decode straight from registered state so reset clears them asynchronously
   assign v_o        = (state_q == S_ALIGN_P) || (state_q == S_N1_P) || (state_q == S_N2_P);
   assign busy_o     = (state_q != S_IDLE);
   assign ack_o      = (state_q == S_FINISH) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign err_code_o = (state_q == S_FINISH) ? err_q : 2'b00;
   assign owner_o    = owner_q;
   assign din_o      = din_q;

endmodule
